dma_axi_wr_engine: RTL and testbench

- DMA write-side engine. Drains the DMA FIFO (first-word-fall-through, push/pull/depth_left style) and moves its contents to memory as AXI4 INCR write bursts.
- Sits on the consumer end of the FIFO; the read engine fills it from the producer end.
- Splits a transfer into bursts of at most MAX_BURST beats, never crossing a 4 KB boundary.
- Issues a burst's address only once the FIFO already holds the whole burst.

---
 rtl/dma_axi_wr_engine.sv | 122 ++++++++++++
 tb/tb_dma_axi_wr_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_wr_engine.sv
// dma_axi_wr_engine: drains a FWFT FIFO into memory as AXI4 INCR write bursts that never cross 4 KB
module dma_axi_wr_engine #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int DLWIDTH    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] dst_addr,
  input  logic [15:0]       num_beats,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              fifo_pull,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic [DLWIDTH-1:0] fifo_depth_left,
  output logic [AWIDTH-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DWIDTH-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);
  typedef enum logic [2:0] {IDLE, CALC, WAITF, ADDR, DATA, RESP, DONE} state_t;
  state_t            state_q;
  logic [AWIDTH-1:0] addr_q, awaddr_q;
  logic [15:0]       rem_q, len_q, room_d, lim_d, len_d, occ_d;
  logic [7:0]        cnt_q, awlen_q;
  logic              busy_q, done_q, error_q;
  // Burst length is the smallest of what is left, the burst cap and the words up to the next 4 KB page.
  always_comb begin
    room_d = {5'd0, 11'd1024 - {1'b0, addr_q[11:2]}};
    lim_d  = rem_q < 16'(MAX_BURST) ? rem_q : 16'(MAX_BURST);
    len_d  = lim_d < room_d ? lim_d : room_d;
    occ_d  = 16'(FIFO_DEPTH) - 16'(fifo_depth_left);
  end
  assign awaddr    = awaddr_q;
  assign awlen     = awlen_q;
  assign awsize    = 3'b010;
  assign awburst   = 2'b01;
  assign awvalid   = state_q == ADDR;
  assign wdata     = fifo_data;
  assign wstrb     = 4'hF;
  assign wvalid    = state_q == DATA && !fifo_empty;
  assign wlast     = state_q == DATA && cnt_q == awlen_q;
  assign fifo_pull = wvalid && wready;
  assign bready    = state_q == RESP;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  // Transfer sequencer: size a burst, wait for the FIFO to hold all of it, then run AW, W and B in turn.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q  <= {dst_addr[AWIDTH-1:2], 2'b00};
          rem_q   <= num_beats;
          error_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= CALC;
        end
        CALC: if (rem_q == 16'd0) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end else begin
          len_q    <= len_d;
          awaddr_q <= addr_q;
          awlen_q  <= 8'(len_d - 16'd1);
          state_q  <= WAITF;
        end
        WAITF: if (occ_d >= len_q) state_q <= ADDR;
        ADDR: if (awready) begin
          cnt_q   <= '0;
          state_q <= DATA;
        end
        DATA: if (fifo_pull) begin
          cnt_q <= cnt_q + 8'd1;
          if (wlast) state_q <= RESP;
        end
        RESP: if (bvalid) begin
          addr_q <= addr_q + (AWIDTH'(len_q) << 2);
          rem_q  <= rem_q - len_q;
          if (bresp != 2'b00) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else state_q <= CALC;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_axi_wr_engine.sv
// tb_dma_axi_wr_engine: directed scenarios against a FIFO model and a reactive AXI write slave
module tb_dma_axi_wr_engine;
  logic clk = 0, rst = 0, start = 0;
  logic [31:0] dst_addr = 0;
  logic [15:0] num_beats = 0;
  logic busy, done, error, fifo_pull, fifo_empty;
  logic [31:0] fifo_data, awaddr, wdata;
  logic [5:0] fifo_depth_left;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;
  logic awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid, bready;
  logic [3:0] wstrb;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  dma_axi_wr_engine dut (
    .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .error(error), .fifo_pull(fifo_pull),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_depth_left(fifo_depth_left),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // FWFT FIFO model
  logic [31:0] mem [64];
  int wp = 0, rp = 0;
  logic push = 0, clr = 0;
  logic [31:0] push_data = 0;
  always @(posedge clk) begin
    if (clr) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (push) begin
        mem[wp % 64] <= push_data;
        wp <= wp + 1;
      end
      if (fifo_pull) rp <= rp + 1;
    end
  end
  assign fifo_empty      = (wp == rp);
  assign fifo_data       = mem[rp % 64];
  assign fifo_depth_left = 6'(32 - (wp - rp));

  // AXI B responder: one response per burst after its last beat, bresp taken from resp_cfg
  logic pend;
  int b_idx;
  logic [1:0] resp_cfg [8];
  always @(posedge clk) begin
    if (clr || !rst) begin
      pend   <= 0;
      bvalid <= 0;
      bresp  <= 0;
      b_idx  <= 0;
    end else begin
      if (wvalid && wready && wlast) pend <= 1;
      if (pend && !bvalid) begin
        bvalid <= 1;
        bresp  <= resp_cfg[b_idx % 8];
        pend   <= 0;
      end
      if (bvalid && bready) begin
        bvalid <= 0;
        b_idx  <= b_idx + 1;
      end
    end
  end

  // Traffic recorder
  int n_aw = 0, n_w = 0, n_last = 0, n_pull = 0, n_done = 0;
  logic [31:0] aw_addr [8];
  logic [7:0]  aw_len [8];
  logic [31:0] w_data [64];
  always @(posedge clk) begin
    if (clr) begin
      n_aw <= 0; n_w <= 0; n_last <= 0; n_pull <= 0; n_done <= 0;
    end else begin
      if (awvalid && awready) begin
        if (n_aw < 8) begin
          aw_addr[n_aw] <= awaddr;
          aw_len[n_aw]  <= awlen;
        end
        n_aw <= n_aw + 1;
      end
      if (wvalid && wready) begin
        if (n_w < 64) w_data[n_w] <= wdata;
        n_w <= n_w + 1;
        if (wlast) n_last <= n_last + 1;
      end
      if (fifo_pull) n_pull <= n_pull + 1;
      if (done) n_done <= n_done + 1;
    end
  end

  task automatic clear_env();
    for (int i = 0; i < 8; i++) resp_cfg[i] = 2'b00;
    @(negedge clk) clr = 1;
    @(negedge clk) clr = 0;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push = 1;
      push_data = base + i;
    end
    @(negedge clk) push = 0;
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk);
    start = 1; dst_addr = a; num_beats = n;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy, done, error, fifo_pull} !== 4'b0) begin n_fail++; $display("FAIL reset_status got %b exp 0000", {busy, done, error, fifo_pull}); end
    n_checks++; if ({awvalid, wvalid, wlast, bready} !== 4'b0) begin n_fail++; $display("FAIL reset_valids got %b exp 0000", {awvalid, wvalid, wlast, bready}); end
    n_checks++; if (awaddr !== 32'h0 || awlen !== 8'h0) begin n_fail++; $display("FAIL reset_aw got %h/%h exp 0/0", awaddr, awlen); end
    n_checks++; if (awsize !== 3'b010 || awburst !== 2'b01 || wstrb !== 4'hF) begin n_fail++; $display("FAIL reset_const got %b/%b/%h exp 010/01/f", awsize, awburst, wstrb); end
    rst = 1;
  endtask

  task automatic test_single();
    bit ok;
    clear_env();
    awready = 1; wready = 1;
    push_words(32'hA0, 4);
    start_xfer(32'h1000, 4);
    @(negedge clk);
    n_checks++; if (awvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_aw got %b exp 0", awvalid); end
    @(negedge clk);
    n_checks++; if (awvalid !== 1'b1) begin n_fail++; $display("FAIL single_aw_latency got %b exp 1", awvalid); end
    wait_done(60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done_timeout got 0 exp 1"); end
    n_checks++; if (error !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_err_busy got %b%b exp 00", error, busy); end
    repeat (3) @(negedge clk);
    n_checks++; if (n_aw !== 1 || aw_addr[0] !== 32'h1000 || aw_len[0] !== 8'd3) begin n_fail++; $display("FAIL single_aw got n=%0d %h/%0d exp 1 1000/3", n_aw, aw_addr[0], aw_len[0]); end
    n_checks++; if (n_w !== 4 || n_last !== 1 || n_pull !== 4 || n_done !== 1) begin n_fail++; $display("FAIL single_counts got w=%0d last=%0d pull=%0d done=%0d exp 4 1 4 1", n_w, n_last, n_pull, n_done); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (w_data[i] !== 32'hA0 + i) begin n_fail++; $display("FAIL single_wdata[%0d] got %h exp %h", i, w_data[i], 32'hA0 + i); end
    end
  endtask

  task automatic test_split();
    bit ok;
    clear_env();
    awready = 1; wready = 1;
    fork
      begin
        int i = 0, t = 0;
        while (i < 40 && t < 2000) begin
          @(negedge clk);
          t++;
          if (wp - rp < 32) begin
            push = 1;
            push_data = 32'hB00 + i;
            i++;
          end else push = 0;
        end
        @(negedge clk) push = 0;
      end
      begin
        start_xfer(32'h2000, 40);
        wait_done(400, ok);
      end
    join
    n_checks++; if (!ok) begin n_fail++; $display("FAIL split_done_timeout got 0 exp 1"); end
    repeat (3) @(negedge clk);
    n_checks++; if (n_aw !== 3) begin n_fail++; $display("FAIL split_naw got %0d exp 3", n_aw); end
    n_checks++; if (aw_addr[0] !== 32'h2000 || aw_addr[1] !== 32'h2040 || aw_addr[2] !== 32'h2080) begin n_fail++; $display("FAIL split_addr got %h %h %h exp 2000 2040 2080", aw_addr[0], aw_addr[1], aw_addr[2]); end
    n_checks++; if (aw_len[0] !== 8'd15 || aw_len[1] !== 8'd15 || aw_len[2] !== 8'd7) begin n_fail++; $display("FAIL split_len got %0d %0d %0d exp 15 15 7", aw_len[0], aw_len[1], aw_len[2]); end
    n_checks++; if (n_w !== 40 || n_last !== 3 || n_done !== 1) begin n_fail++; $display("FAIL split_counts got w=%0d last=%0d done=%0d exp 40 3 1", n_w, n_last, n_done); end
    n_checks++; if (w_data[0] !== 32'hB00 || w_data[16] !== 32'hB10 || w_data[39] !== 32'hB27) begin n_fail++; $display("FAIL split_wdata got %h %h %h exp b00 b10 b27", w_data[0], w_data[16], w_data[39]); end
  endtask

  task automatic test_4k();
    bit ok;
    logic [31:0] starts [2] = '{32'h0FF8, 32'h0FFB};
    for (int r = 0; r < 2; r++) begin
      clear_env();
      awready = 1; wready = 1;
      push_words(32'hF0, 6);
      start_xfer(starts[r], 6);
      wait_done(80, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL k4_done_timeout[%0d] got 0 exp 1", r); end
      repeat (3) @(negedge clk);
      n_checks++; if (n_aw !== 2 || aw_addr[0] !== 32'h0FF8 || aw_len[0] !== 8'd1) begin n_fail++; $display("FAIL k4_first[%0d] got n=%0d %h/%0d exp 2 ff8/1", r, n_aw, aw_addr[0], aw_len[0]); end
      n_checks++; if (aw_addr[1] !== 32'h1000 || aw_len[1] !== 8'd3 || n_w !== 6) begin n_fail++; $display("FAIL k4_second[%0d] got %h/%0d w=%0d exp 1000/3 6", r, aw_addr[1], aw_len[1], n_w); end
    end
  endtask

  task automatic test_flow();
    bit ok;
    bit pat [6] = '{1, 0, 0, 1, 1, 1};
    int idx [6] = '{0, 1, 1, 1, 2, 3};
    clear_env();
    awready = 0; wready = 0;
    push_words(32'hC0, 3);
    start_xfer(32'h3000, 4);
    repeat (5) @(negedge clk);
    n_checks++; if (awvalid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL flow_wait_fifo got aw=%b busy=%b exp 0 1", awvalid, busy); end
    push_words(32'hC3, 1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (awvalid) begin ok = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flow_aw_timeout got 0 exp 1"); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (awvalid !== 1'b1 || awaddr !== 32'h3000 || awlen !== 8'd3 || wvalid !== 1'b0) begin n_fail++; $display("FAIL flow_aw_hold[%0d] got %b %h %0d w=%b exp 1 3000 3 0", k, awvalid, awaddr, awlen, wvalid); end
    end
    awready = 1;
    @(negedge clk) awready = 0;
    n_checks++; if (awvalid !== 1'b0 || wvalid !== 1'b1) begin n_fail++; $display("FAIL flow_w_after_aw got aw=%b w=%b exp 0 1", awvalid, wvalid); end
    for (int k = 0; k < 6; k++) begin
      wready = pat[k];
      #1;
      n_checks++; if (fifo_pull !== pat[k] || wdata !== 32'hC0 + idx[k]) begin n_fail++; $display("FAIL flow_w[%0d] got pull=%b data=%h exp %b %h", k, fifo_pull, wdata, pat[k], 32'hC0 + idx[k]); end
      if (k == 5) begin
        n_checks++; if (wlast !== 1'b1) begin n_fail++; $display("FAIL flow_wlast got %b exp 1", wlast); end
      end
      @(negedge clk);
    end
    wready = 1;
    wait_done(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flow_done_timeout got 0 exp 1"); end
    repeat (2) @(negedge clk);
    n_checks++; if (n_w !== 4 || n_pull !== 4 || n_aw !== 1) begin n_fail++; $display("FAIL flow_counts got w=%0d pull=%0d aw=%0d exp 4 4 1", n_w, n_pull, n_aw); end
  endtask

  task automatic test_error();
    bit ok;
    clear_env();
    resp_cfg[0] = 2'b10;
    awready = 1; wready = 1;
    push_words(32'hE00, 16);
    start_xfer(32'h5000, 40);
    wait_done(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL err_done_timeout got 0 exp 1"); end
    n_checks++; if (error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_flag got err=%b busy=%b exp 1 0", error, busy); end
    repeat (5) @(negedge clk);
    n_checks++; if (n_aw !== 1 || n_w !== 16 || n_done !== 1) begin n_fail++; $display("FAIL err_counts got aw=%0d w=%0d done=%0d exp 1 16 1", n_aw, n_w, n_done); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", error); end
    clear_env();
    start_xfer(32'h0, 0);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", error); end
    wait_done(10, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_env();
    awready = 1; wready = 0;
    push_words(32'hD0, 8);
    start_xfer(32'h6000, 8);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (wvalid) begin ok = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_data_timeout got 0 exp 1"); end
    rst = 0;
    @(negedge clk);
    n_checks++; if ({awvalid, wvalid, wlast, bready, fifo_pull, busy, done} !== 7'b0) begin n_fail++; $display("FAIL rmid_outputs got %b exp 0000000", {awvalid, wvalid, wlast, bready, fifo_pull, busy, done}); end
    n_checks++; if (awaddr !== 32'h0 || awlen !== 8'h0) begin n_fail++; $display("FAIL rmid_aw got %h/%h exp 0/0", awaddr, awlen); end
    rst = 1;
    wready = 1;
  endtask

  task automatic test_zero();
    clear_env();
    awready = 1;
    start_xfer(32'h7000, 0);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_n1 got busy=%b done=%b exp 1 0", busy, done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_n2 got done=%b busy=%b exp 1 0", done, busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse got %b exp 0", done); end
    repeat (4) @(negedge clk);
    n_checks++; if (n_aw !== 0 || n_w !== 0 || n_done !== 1) begin n_fail++; $display("FAIL zero_traffic got aw=%0d w=%0d done=%0d exp 0 0 1", n_aw, n_w, n_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_4k();
    test_flow();
    test_error();
    test_reset_mid();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule
